// File: rtl/score_bus_writer_if.sv
// Score write bus between the score keeper (master) and the display register file (slave).
interface score_bus_writer_if;
  logic        bus_busy_i;
  logic        MW_o;
  logic [1:0]  address_o;
  logic [31:0] data_o;

  modport master (input bus_busy_i, output MW_o, address_o, data_o);
  modport slave  (output bus_busy_i, input MW_o, address_o, data_o);
endinterface

// File: rtl/score_bus_writer.sv
// Two-player score keeper that mirrors each changed score onto a shared write bus.
// Optional win detection is enabled by defining SCORE_WIN_DETECT_EN.
module score_bus_writer #(
  parameter int WIN_SCORE = 5,
  parameter int MAX_SCORE = 9
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic                       goal1_i,
  input  logic                       goal2_i,
  input  logic                       clear_i,
  output logic [3:0]                 score1_o,
  output logic [3:0]                 score2_o,
  output logic                       game_over_o,
  output logic [1:0]                 winner_o,
  output logic                       pending_o,
  score_bus_writer_if.master         bus
);

  // Clamp so a WIN_SCORE above MAX_SCORE can still be reached.
  localparam logic [3:0] SAT = 4'((MAX_SCORE < WIN_SCORE) ? WIN_SCORE : MAX_SCORE);

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic        dirty1_q, dirty1_d, dirty2_q, dirty2_d;
  logic        mw_q, mw_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        g1, g2;

`ifdef SCORE_WIN_DETECT_EN
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  logic       go_q, go_d;
  logic [1:0] win_q, win_d;
  logic       hit1, hit2;

  // A finished game freezes both scores until clear or reset.
  assign g1 = goal1_i & ~go_q;
  assign g2 = goal2_i & ~go_q;
`else
  assign g1 = goal1_i;
  assign g2 = goal2_i;
`endif

  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    if (clear_i) begin
      score1_d = '0;
      score2_d = '0;
    end else begin
      if (g1 && score1_q != SAT) score1_d = score1_q + 4'd1;
      if (g2 && score2_q != SAT) score2_d = score2_q + 4'd1;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = dirty1_q ? WR1 : (dirty2_q ? WR2 : IDLE);
      WR1:     state_d = dirty2_q ? WR2 : (dirty1_q ? WR1 : IDLE);
      WR2:     state_d = dirty1_q ? WR1 : (dirty2_q ? WR2 : IDLE);
      default: state_d = IDLE;
    endcase
    if (bus.bus_busy_i) state_d = IDLE;
  end

  // A goal landing on the capture edge keeps the flag set so the newer value is sent later.
  always_comb begin
    dirty1_d = clear_i | g1 | (dirty1_q & (state_d != WR1));
    dirty2_d = clear_i | g2 | (dirty2_q & (state_d != WR2));
    mw_d     = (state_d != IDLE);
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_d)
      WR1: begin
        addr_d = 2'b00;
        data_d = {28'd0, score1_q};
      end
      WR2: begin
        addr_d = 2'b01;
        data_d = {28'd0, score2_q};
      end
      default: ;
    endcase
  end

`ifdef SCORE_WIN_DETECT_EN
  always_comb begin
    hit1  = g1 && !clear_i && (score1_d == WIN) && (score1_q != WIN);
    hit2  = g2 && !clear_i && (score2_d == WIN) && (score2_q != WIN);
    go_d  = clear_i ? 1'b0 : (go_q | hit1 | hit2);
    win_d = clear_i ? 2'b00 : (go_q ? win_q : {hit2, hit1});
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      go_q  <= 1'b0;
      win_q <= 2'b00;
    end else begin
      go_q  <= go_d;
      win_q <= win_d;
    end
  end

  assign game_over_o = go_q;
  assign winner_o    = win_q;
`else
  assign game_over_o = 1'b0;
  assign winner_o    = 2'b00;
`endif

  // Dirty flags come out of reset set so the display is loaded with zeros.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      score1_q <= '0;
      score2_q <= '0;
      dirty1_q <= 1'b1;
      dirty2_q <= 1'b1;
      mw_q     <= 1'b0;
      addr_q   <= 2'b00;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dirty1_q <= dirty1_d;
      dirty2_q <= dirty2_d;
      mw_q     <= mw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign score1_o      = score1_q;
  assign score2_o      = score2_q;
  assign pending_o     = dirty1_q | dirty2_q;
  assign bus.MW_o      = mw_q;
  assign bus.address_o = addr_q;
  assign bus.data_o    = data_q;

endmodule

// File: tb/tb_score_bus_writer.sv
// Directed vector table plus hand-written sequences for score_bus_writer.
module tb_score_bus_writer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       goal1 = 1'b0, goal2 = 1'b0, clear = 1'b0;
  logic [3:0] s1, s2;
  logic       go, pend;
  logic [1:0] win;
  int         total = 0, bad = 0;
  int         nwr1 = 0, nwr2 = 0;
  logic [31:0] last1 = 32'hff, last2 = 32'hff;

`ifdef SCORE_WIN_DETECT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  score_bus_writer_if bus ();

  score_bus_writer #(.WIN_SCORE(5), .MAX_SCORE(9)) dut (
    .clk(clk), .rst_n_i(rst_n), .goal1_i(goal1), .goal2_i(goal2), .clear_i(clear),
    .score1_o(s1), .score2_o(s2), .game_over_o(go), .winner_o(win), .pending_o(pend),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit g1, g2, clr, busy;
    bit mw; bit [1:0] addr; bit [31:0] data;
    bit [3:0] s1, s2; bit pend, go; bit [1:0] win;
  } vec_t;

  vec_t tv[31];

  function automatic vec_t mk(bit g1, bit g2, bit clr, bit busy, bit mw, bit [1:0] addr,
                              bit [31:0] data, bit [3:0] a, bit [3:0] b, bit p, bit g, bit [1:0] w);
    vec_t v;
    v.g1 = g1; v.g2 = g2; v.clr = clr; v.busy = busy;
    v.mw = mw; v.addr = addr; v.data = data; v.s1 = a; v.s2 = b;
    v.pend = p; v.go = g; v.win = w;
    return v;
  endfunction

  function automatic logic [63:0] obs();
    return {17'd0, bus.MW_o, bus.address_o, bus.data_o, s1, s2, pend, go, win};
  endfunction

  function automatic logic [63:0] ex(vec_t v);
    return {17'd0, v.mw, v.addr, v.data, v.s1, v.s2, v.pend, v.go, v.win};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, pulse across a posedge, observe at the next negedge.
  task automatic step(bit g1, bit g2, bit clr, bit busy);
    goal1 = g1; goal2 = g2; clear = clr; bus.bus_busy_i = busy;
    @(posedge clk);
    #1;
    goal1 = 1'b0; goal2 = 1'b0; clear = 1'b0;
    @(negedge clk);
    if (bus.MW_o && bus.address_o == 2'b00) begin last1 = bus.data_o; nwr1++; end
    if (bus.MW_o && bus.address_o == 2'b01) begin last2 = bus.data_o; nwr2++; end
  endtask

  initial begin
    bus.bus_busy_i = 1'b0;
    //           g1 g2 cl by  mw ad data s1 s2 pd go  win
    tv[0]  = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 1, 0,  0);
    tv[1]  = mk(0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0,  0);
    tv[2]  = mk(0, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0,  0);
    tv[3]  = mk(1, 0, 0, 0,  0, 1, 0,  1, 0, 1, 0,  0);
    tv[4]  = mk(0, 0, 0, 0,  1, 0, 1,  1, 0, 0, 0,  0);
    tv[5]  = mk(0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0,  0);
    tv[6]  = mk(0, 1, 0, 0,  0, 0, 1,  1, 1, 1, 0,  0);
    tv[7]  = mk(0, 1, 0, 0,  1, 1, 1,  1, 2, 1, 0,  0);
    tv[8]  = mk(0, 1, 0, 0,  1, 1, 2,  1, 3, 1, 0,  0);
    tv[9]  = mk(0, 0, 0, 0,  1, 1, 3,  1, 3, 0, 0,  0);
    tv[10] = mk(0, 0, 0, 0,  0, 1, 3,  1, 3, 0, 0,  0);
    tv[11] = mk(1, 1, 0, 0,  0, 1, 3,  2, 4, 1, 0,  0);
    tv[12] = mk(0, 0, 0, 0,  1, 0, 2,  2, 4, 1, 0,  0);
    tv[13] = mk(0, 0, 0, 0,  1, 1, 4,  2, 4, 0, 0,  0);
    tv[14] = mk(0, 0, 0, 0,  0, 1, 4,  2, 4, 0, 0,  0);
    tv[15] = mk(0, 0, 0, 1,  0, 1, 4,  2, 4, 0, 0,  0);
    tv[16] = mk(1, 0, 0, 1,  0, 1, 4,  3, 4, 1, 0,  0);
    tv[17] = mk(1, 0, 0, 1,  0, 1, 4,  4, 4, 1, 0,  0);
    tv[18] = mk(0, 0, 0, 1,  0, 1, 4,  4, 4, 1, 0,  0);
    tv[19] = mk(0, 0, 0, 1,  0, 1, 4,  4, 4, 1, 0,  0);
    tv[20] = mk(0, 0, 0, 0,  1, 0, 4,  4, 4, 0, 0,  0);
    tv[21] = mk(0, 0, 0, 0,  0, 0, 4,  4, 4, 0, 0,  0);
    tv[22] = mk(1, 1, 0, 0,  0, 0, 4,  5, 5, 1, WD, WD ? 2'b11 : 2'b00);
    tv[23] = mk(0, 0, 0, 0,  1, 0, 5,  5, 5, 1, WD, WD ? 2'b11 : 2'b00);
    tv[24] = mk(0, 0, 0, 1,  0, 0, 5,  5, 5, 1, WD, WD ? 2'b11 : 2'b00);
    tv[25] = mk(0, 0, 0, 0,  1, 1, 5,  5, 5, 0, WD, WD ? 2'b11 : 2'b00);
    tv[26] = mk(0, 0, 0, 0,  0, 1, 5,  5, 5, 0, WD, WD ? 2'b11 : 2'b00);
    tv[27] = mk(1, 0, 1, 0,  0, 1, 5,  0, 0, 1, 0,  0);
    tv[28] = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 1, 0,  0);
    tv[29] = mk(0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0,  0);
    tv[30] = mk(0, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0,  0);

    // Reset state, both scores owed to the display.
    repeat (2) @(negedge clk);
    chk("reset_state", obs(), {17'd0, 1'b0, 2'b00, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00});
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      step(tv[i].g1, tv[i].g2, tv[i].clr, tv[i].busy);
      chk($sformatf("vec%0d", i), obs(), ex(tv[i]));
    end

`ifndef SCORE_WIN_DETECT_EN
    // Saturation of player 2.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("sat_score2", 64'(s2), 64'd9);
    chk("sat_last_data", 64'(last2), 64'd9);
    chk("sat_gameover_tied", 64'({go, win}), 64'd0);
    nwr2 = 0; last2 = 32'hff;
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("sat_goal_rewrite_cnt", 64'(nwr2), 64'd1);
    chk("sat_goal_rewrite_data", 64'(last2), 64'd9);
    chk("sat_pending", 64'(pend), 64'd0);
`else
    // Player 1 wins; later goals are ignored until clear.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("win_state", 64'({go, win, s1}), 64'({1'b1, 2'b01, 4'd5}));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("win_frozen", 64'({s1, pend, go}), 64'({4'd5, 1'b0, 1'b1}));
    nwr1 = 0; nwr2 = 0; last1 = 32'hff; last2 = 32'hff;
    step(0, 0, 1, 0);
    chk("win_clear", 64'({go, win}), 64'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("win_clear_writes", 64'({nwr1[7:0], nwr2[7:0], last1, last2}), 64'({8'd1, 8'd1, 32'd0, 32'd0}));
`endif

    // Reset in the middle of a write drops the strobe without a clock edge.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_reset_write", 64'({bus.MW_o, bus.address_o}), 64'({1'b1, 2'b00}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({bus.MW_o, s1, pend, bus.data_o}), 64'({1'b0, 4'd0, 1'b1, 32'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("rel_wr1", obs(), {17'd0, 1'b1, 2'b00, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00});
    step(0, 0, 0, 0);
    chk("rel_wr2", obs(), {17'd0, 1'b1, 2'b01, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00});
    step(0, 0, 0, 0);
    chk("rel_idle", obs(), {17'd0, 1'b0, 2'b01, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/score_bus_writer.md
SCORE_BUS_WRITER -- requirements
Module: score_bus_writer

Interface
REQ-001 Parameter WIN_SCORE, default 5, score that ends the game; SHALL satisfy 1 <= WIN_SCORE <= MAX_SCORE.
REQ-002 Parameter MAX_SCORE, default 9, saturation value and highest digit sprite index.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-005 goal1_i / goal2_i  input  1 each  one-cycle point pulse for player 1 / player 2.
REQ-006 clear_i  input  1  one-cycle pulse; zeroes both scores and starts a new game.
REQ-007 bus_busy_i  input  1  another master owns the score write bus; no write may start.
REQ-008 MW_o  output  1  score write strobe, one cycle per write.
REQ-009 address_o  output  2  score register select: 00 = player 1, 01 = player 2.
REQ-010 data_o  output  32  score value, zero-extended.
REQ-011 score1_o / score2_o  output  4 each  current score registers.
REQ-012 game_over_o  output  1  a player has reached WIN_SCORE.
REQ-013 winner_o  output  2  01 = player 1, 10 = player 2, 11 = both same edge, 00 = none.
REQ-014 pending_o  output  1  OR of both dirty flags.

Function
REQ-015 At a posedge where goalN_i = 1, scoreN SHALL increment by 1, saturating at MAX_SCORE, and dirtyN SHALL set.
REQ-016 A goal at saturation SHALL leave the score unchanged but still set dirtyN.
REQ-017 At a posedge where clear_i = 1, both scores SHALL go to 0 and both dirty flags SHALL set.
REQ-018 clear_i SHALL override any same-edge goals, and game_over_o and winner_o SHALL clear.
REQ-019 The FSM SHALL have states IDLE, WR1 and WR2, all registered.
REQ-020 MW_o SHALL be 1 exactly in WR1 and WR2.
REQ-021 In WR1, address_o SHALL be 00; in WR2, address_o SHALL be 01.
REQ-022 data_o SHALL equal the score captured at the edge entering the WR state.
REQ-023 Next state from any state when bus_busy_i = 1 SHALL be IDLE.
REQ-024 Next state from IDLE with bus_busy_i = 0 SHALL be WR1 if dirty1, else WR2 if dirty2, else IDLE.
REQ-025 Next state from WR1 with bus_busy_i = 0 SHALL be WR2 if dirty2, else WR1 if dirty1, else IDLE.
REQ-026 Next state from WR2 with bus_busy_i = 0 SHALL be WR1 if dirty1, else WR2 if dirty2, else IDLE.
REQ-027 dirtyN SHALL clear at the edge entering WRN, unless goalN_i or clear_i is sampled on that same edge; then it stays set and a later write carries the newer value.
REQ-028 Latency: a goal sampled at edge E SHALL produce MW_o = 1 in the cycle after E+1 when the bus is free and no other write has priority.
REQ-029 Simultaneous goals SHALL produce two consecutive writes, player 1 first.
REQ-030 Outputs SHALL change only on posedge; the consumer samples on negedge, mid-cycle.
REQ-031 When bus_busy_i = 1, MW_o SHALL be 0 in the following cycle, address_o and data_o SHALL hold, and pending writes wait.
REQ-032 pending_o SHALL be combinational from the dirty flags.

Reset
REQ-033 While rst_n_i = 0: scores 0, state IDLE, MW_o 0, address_o 00, data_o 0, game_over_o 0, winner_o 00.
REQ-034 While rst_n_i = 0, dirty1 and dirty2 SHALL be 1, so the display receives zeros after reset.
REQ-035 The first two enabled edges after release SHALL enter WR1 (data 0), then WR2 (data 0), if the bus is free.
REQ-036 Reset asserted mid-write SHALL drop MW_o immediately, asynchronously.

Configuration
REQ-037 The macro SCORE_WIN_DETECT_EN SHALL enable win detection.
REQ-038 With the macro defined, game_over_o SHALL set at the edge where any score becomes WIN_SCORE, and winner_o SHALL latch.
REQ-039 With the macro defined, goals SHALL be ignored while game_over_o = 1 (no increment, no dirty) until clear_i or reset.
REQ-040 With the macro undefined, game_over_o and winner_o SHALL be tied 0, and goals are always counted with saturation.

Verification
REQ-041 Reset release, bus idle -> MW_o pulses with address 00/data 0, then address 01/data 0, in the first two cycles; then pending_o = 0.
REQ-042 goal1_i once -> score1_o = 1 the next cycle; one MW_o pulse with address 00, data 1.
REQ-043 goal1_i and goal2_i on the same edge, with score2 = 3 -> consecutive writes: address 00/data 1, then address 01/data 4.
REQ-044 bus_busy_i high for 5 cycles around a goal -> no MW_o while busy; a single write with the final value one cycle after release.
REQ-045 Ten goal2_i pulses, macro undefined, MAX_SCORE 9 -> score2_o saturates at 9; last write data 9.
REQ-046 Macro defined, player 1 reaches 5 -> game_over_o = 1, winner_o = 01; a further goal1_i leaves score1_o at 5; clear_i writes 0 and 0.
